// File: rtl/point_vec_packer.sv
// point_vec_packer: stream-to-vector packer for the lane-parallel modular multiplier.
// Collects (a, b) coefficient pairs into D-lane packed vectors, double-buffered
// (fill register + output register) behind valid/ready handshakes on both sides.
// Optional range check on incoming coefficients: define POINT_VEC_PACKER_RANGE_CHECK_EN.
module point_vec_packer #(
  parameter int unsigned N = 19,
  parameter int unsigned D = 8,
  parameter int unsigned Q = 270337
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D*N-1:0]         out_a,
  output logic [D*N-1:0]         out_b,
  output logic [$clog2(D+1)-1:0] out_count,
  output logic                   out_last,
  output logic                   err
);

  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned VW = D * N;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // The modulus must be representable in a lane
  if (64'(Q) >= (64'd1 << N)) begin : g_q_range
    $error("point_vec_packer: Q must be below 2**N");
  end

  logic [0:0]    state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [VW-1:0] fill_a, fill_a_n, fill_b, fill_b_n;
  logic [CW-1:0] fill_cnt, fill_cnt_n;
  logic          fill_last, fill_last_n;
  logic          in_ready_n, out_valid_n, out_last_n;
  logic [VW-1:0] out_a_n, out_b_n;
  logic [CW-1:0] out_count_n;
  logic [VW-1:0] beat_a, beat_b;
  logic          accept, closing, out_free;
  logic          err_n;

  // Next-state: lane writes, vector close, hand-off to the output register
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    fill_a_n    = fill_a;
    fill_b_n    = fill_b;
    fill_cnt_n  = fill_cnt;
    fill_last_n = fill_last;
    out_valid_n = out_valid;
    out_a_n     = out_a;
    out_b_n     = out_b;
    out_count_n = out_count;
    out_last_n  = out_last;
    beat_a      = fill_a;
    beat_b      = fill_b;

    accept   = in_valid && in_ready;
    out_free = !out_valid || out_ready;
    closing  = accept && ((idx == IW'(D - 1)) || in_last);

    // Fill register with the current beat merged into lane idx
    for (int i = 0; i < D; i++) begin
      if (IW'(i) == idx) begin
        beat_a[i*N +: N] = in_a;
        beat_b[i*N +: N] = in_b;
      end
    end

    if (out_valid && out_ready) out_valid_n = 1'b0;

    case (state)
      S_FILL: begin
        if (accept) begin
          if (closing && out_free) begin
            out_valid_n = 1'b1;
            out_a_n     = beat_a;
            out_b_n     = beat_b;
            out_count_n = CW'(idx) + CW'(1);
            out_last_n  = in_last;
            fill_a_n    = '0;
            fill_b_n    = '0;
            idx_n       = '0;
          end else if (closing) begin
            fill_a_n    = beat_a;
            fill_b_n    = beat_b;
            fill_cnt_n  = CW'(idx) + CW'(1);
            fill_last_n = in_last;
            state_n     = S_WAIT;
          end else begin
            fill_a_n = beat_a;
            fill_b_n = beat_b;
            idx_n    = idx + IW'(1);
          end
        end
      end
      S_WAIT: begin
        if (out_free) begin
          out_valid_n = 1'b1;
          out_a_n     = fill_a;
          out_b_n     = fill_b;
          out_count_n = fill_cnt;
          out_last_n  = fill_last;
          fill_a_n    = '0;
          fill_b_n    = '0;
          fill_cnt_n  = '0;
          fill_last_n = 1'b0;
          idx_n       = '0;
          state_n     = S_FILL;
        end
      end
      default: state_n = S_FILL;
    endcase

    in_ready_n = (state_n == S_FILL);
  end

`ifdef POINT_VEC_PACKER_RANGE_CHECK_EN
  localparam logic [N-1:0] QV = N'(Q);
  logic err_q;

  // Sticky flag for any accepted coefficient outside [0, Q)
  always_comb begin
    err_n = err_q | (accept && ((in_a >= QV) || (in_b >= QV)));
  end

  // Range error register
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_n;
  end

  assign err = err_q;
`else
  // Range check compiled out
  always_comb err_n = 1'b0;
  assign err = err_n;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FILL;
      idx       <= '0;
      fill_a    <= '0;
      fill_b    <= '0;
      fill_cnt  <= '0;
      fill_last <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      fill_a    <= fill_a_n;
      fill_b    <= fill_b_n;
      fill_cnt  <= fill_cnt_n;
      fill_last <= fill_last_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_a     <= out_a_n;
      out_b     <= out_b_n;
      out_count <= out_count_n;
      out_last  <= out_last_n;
    end
  end

endmodule

// File: tb/tb_point_vec_packer.sv
// Self-checking bench for point_vec_packer: directed scenarios plus random
// traffic, checked against a queue-based model of emitted vectors.
module tb_point_vec_packer;

  localparam int unsigned N  = 19;
  localparam int unsigned D  = 8;
  localparam int unsigned Q  = 270337;
  localparam int unsigned CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_a = '0;
  logic [N-1:0]    in_b = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [D*N-1:0]  out_a, out_b;
  logic [CW-1:0]   out_count;
  logic            out_last;
  logic            err;

  point_vec_packer #(.N(N), .D(D), .Q(Q)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_count(out_count), .out_last(out_last),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D*N-1:0] a;
    logic [D*N-1:0] b;
    logic [CW-1:0]  cnt;
    logic           last;
  } vec_t;

  // Model: vectors produced but not yet consumed (output reg first, then held fill)
  vec_t         q[$];
  logic [N-1:0] m_a[D];
  logic [N-1:0] m_b[D];
  int           m_idx = 0;
  logic         m_err = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [D*N-1:0] obs, input logic [D*N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic l);
    vec_t v;
    m_a[m_idx] = a;
    m_b[m_idx] = b;
`ifdef POINT_VEC_PACKER_RANGE_CHECK_EN
    if (a >= N'(Q) || b >= N'(Q)) m_err = 1'b1;
`endif
    if (m_idx == D - 1 || l) begin
      v = '0;
      for (int i = 0; i <= m_idx; i++) begin
        v.a[i*N +: N] = m_a[i];
        v.b[i*N +: N] = m_b[i];
      end
      v.cnt  = CW'(m_idx + 1);
      v.last = l;
      q.push_back(v);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model at the edge
  task automatic cyc(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic l, input logic ordy);
    bit exp_rdy, acc, drain;
    in_valid = v; in_a = a; in_b = b; in_last = l; out_ready = ordy;
    exp_rdy = (q.size() < 2);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() > 0);
    chk("err", err, m_err);
    if (q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_count", out_count, q[0].cnt);
      chk("out_last", out_last, q[0].last);
    end
    acc   = v && exp_rdy;
    drain = (q.size() > 0) && ordy;
    if (drain) void'(q.pop_front());
    if (acc) model_beat(a, b, l);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_idx = 0;
    m_err = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_b", out_b, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 6; k++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drained", q.size(), 0);
  endtask

  function automatic logic [N-1:0] rnd();
    return N'($urandom);
  endfunction

  initial begin
    logic [N-1:0] ra, rb;
    do_reset();

    // Full vector, lane i = i+1 / 2i+2
    for (int i = 0; i < D; i++) cyc(1'b1, N'(i + 1), N'(2 * (i + 1)), 1'b0, 1'b1);
    chk("full_count", out_count, 8);
    chk("full_lane7_a", out_a[7*N +: N], 8);
    chk("full_lane0_b", out_b[0 +: N], 2);
    drain_all();

    // Short vector closed by in_last, then next vector starts at lane 0
    cyc(1'b1, 5, 9, 1'b0, 1'b1);
    cyc(1'b1, 6, 10, 1'b0, 1'b1);
    cyc(1'b1, 7, 11, 1'b1, 1'b1);
    chk("short_count", out_count, 3);
    chk("short_last", out_last, 1);
    chk("short_upper_zero", out_a[D*N-1:3*N], 0);
    cyc(1'b1, 100, 200, 1'b1, 1'b1);
    chk("restart_lane0", out_a, 100);
    drain_all();

    // Backpressure: 16 beats with sink stalled, then a single ready pulse
    for (int i = 0; i < 16; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    chk("bp_wait_ready", in_ready, 0);
    cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    drain_all();

    // Back-to-back: 32 beats, sink always ready
    for (int i = 0; i < 32; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    drain_all();

    // Reset mid-fill discards the partial vector
    for (int i = 0; i < 4; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < D; i++) cyc(1'b1, N'(50 + i), N'(60 + i), 1'b0, 1'b1);
    chk("post_rst_count", out_count, 8);
    drain_all();

    // Reset while in WAIT drops the pending output
    for (int i = 0; i < 16; i++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    do_reset();

`ifdef POINT_VEC_PACKER_RANGE_CHECK_EN
    // Out-of-range coefficient sets a sticky error, data passes unchanged
    cyc(1'b1, N'(Q), 5, 1'b1, 1'b1);
    chk("range_err_set", err, 1);
    chk("range_lane_data", out_a[0 +: N], N'(Q));
    cyc(1'b1, 3, 4, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    chk("range_err_sticky", err, 1);
    do_reset();
`endif

    // Random traffic with random last and sink stalls
    for (int i = 0; i < 500; i++) begin
      ra = rnd();
      rb = rnd();
`ifdef POINT_VEC_PACKER_RANGE_CHECK_EN
      if (i < 250) begin
        ra = N'(ra % Q);
        rb = N'(rb % Q);
      end
`endif
      cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 5) == 0,
          $urandom_range(0, 2) != 0);
    end
    drain_all();
`ifndef POINT_VEC_PACKER_RANGE_CHECK_EN
    chk("err_tied_zero", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
